c432_key_loader: RTL and testbench

//  Serial key-programming controller for the MUX4-locked c432 interrupt netlist. Receives the
//  40 key bits p1..p40 over a valid/ready bit-serial link and assembles them in a shadow register.

---
 rtl/c432_key_pkg.sv | 14 +
 rtl/c432_key_if.sv | 15 +
 rtl/c432_key_shreg.sv | 19 +
 rtl/c432_key_loader.sv | 84 ++++++++
 tb/tb_c432_key_loader.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/c432_key_pkg.sv
// c432_key_pkg: shared types and constants for the c432 MUX4 key loader.
package c432_key_pkg;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SHIFT  = 3'd1,
      ST_CHECK  = 3'd2,
      ST_COMMIT = 3'd3,
      ST_LOCKED = 3'd4,
      ST_ERROR  = 3'd5
   } key_ld_state_t;
   localparam int KEY_W_DEF  = 40;
   localparam int MUX_GROUPS = 10;
   localparam int GROUP_W    = 4;
endpackage

// File: rtl/c432_key_if.sv
// c432_key_if: serial key link plus committed key bus; master drives the link, slave is the loader.
interface c432_key_if #(parameter int KEY_W = 40);
   logic             load_start;
   logic             key_valid;
   logic             key_bit;
   logic             key_ready;
   logic [KEY_W-1:0] key_out;
   logic             key_locked;
   logic             load_done;
   logic             load_err;
   modport master (output load_start, key_valid, key_bit,
                   input  key_ready, key_out, key_locked, load_done, load_err);
   modport slave  (input  load_start, key_valid, key_bit,
                   output key_ready, key_out, key_locked, load_done, load_err);
endinterface

// File: rtl/c432_key_shreg.sv
// c432_key_shreg: indexed shadow register with per-bit write enable and synchronous clear.
module c432_key_shreg #(
   parameter int W  = 40,
   parameter int IW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          we,
   input  logic [IW-1:0] idx,
   input  logic          d,
   output logic [W-1:0]  q
);
   // clear wins over a write so a new load always starts from an all-zero shadow
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (clr) q <= '0;
      else if (we) q[idx] <= d;
endmodule

// File: rtl/c432_key_loader.sv
// c432_key_loader: bit-serial key programming with atomic commit; KEY_PARITY_EN adds a trailing even-parity check.
module c432_key_loader
   import c432_key_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEF,
   parameter int CNT_W = 6
) (
   input logic     clk,
   input logic     rst_n,
   c432_key_if.slave bus
);
   localparam logic [2:0] IDLE   = ST_IDLE;
   localparam logic [2:0] SHIFT  = ST_SHIFT;
   localparam logic [2:0] CHECK  = ST_CHECK;
   localparam logic [2:0] COMMIT = ST_COMMIT;
   localparam logic [2:0] LOCKED = ST_LOCKED;
   localparam logic [2:0] ERROR  = ST_ERROR;
`ifdef KEY_PARITY_EN
   localparam logic [2:0] AFTER_SHIFT = CHECK;
`else
   localparam logic [2:0] AFTER_SHIFT = COMMIT;
`endif

   logic [2:0]       state, nxt;
   logic [CNT_W-1:0] cnt;
   logic [KEY_W-1:0] shadow, key_q;
   logic             locked_q;
   logic             xfer, start_ok, last;

   assign xfer     = bus.key_valid && bus.key_ready;
   assign start_ok = bus.load_start && (state == IDLE || state == LOCKED || state == ERROR);
   assign last     = cnt == CNT_W'(KEY_W - 1);

   c432_key_shreg #(.W(KEY_W), .IW(CNT_W)) u_shreg (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_ok),
      .we    (xfer && state == SHIFT),
      .idx   (cnt),
      .d     (bus.key_bit),
      .q     (shadow)
   );

   // next-state decode; load_start outside IDLE/LOCKED/ERROR is ignored
   always_comb begin
      nxt = state;
      case (state)
         IDLE, LOCKED, ERROR: nxt = start_ok ? SHIFT : state;
         SHIFT:  nxt = (xfer && last) ? AFTER_SHIFT : SHIFT;
`ifdef KEY_PARITY_EN
         CHECK:  nxt = xfer ? ((^shadow ^ bus.key_bit) ? ERROR : COMMIT) : CHECK;
`endif
         COMMIT: nxt = LOCKED;
         default: nxt = IDLE;
      endcase
   end

   // state, bit counter and the committed key; key_out only moves on the COMMIT edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         key_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         state <= nxt;
         if (start_ok) cnt <= '0;
         else if (xfer && state == SHIFT) cnt <= cnt + 1'b1;
         if (state == COMMIT) begin
            key_q    <= shadow;
            locked_q <= 1'b1;
         end
      end

   assign bus.key_ready  = state == SHIFT || state == CHECK;
   assign bus.key_out    = key_q;
   assign bus.key_locked = locked_q;
   assign bus.load_done  = state == COMMIT;
`ifdef KEY_PARITY_EN
   assign bus.load_err   = state == ERROR;
`else
   assign bus.load_err   = 1'b0;
`endif
endmodule

// File: tb/tb_c432_key_loader.sv
// tb_c432_key_loader: table-driven key loads plus hand-written reset and parity sequences.
module tb_c432_key_loader;
   import c432_key_pkg::*;
   localparam int KW = KEY_W_DEF;
`ifdef KEY_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   typedef struct {
      logic [KW-1:0] key;
      bit            gap;
      bit            poke;
      int            exp_cyc;
      logic [KW-1:0] exp_key;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   vec_t vt[5];

   c432_key_if #(.KEY_W(KW)) bus ();
   c432_key_loader #(.KEY_W(KW), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // cycle 1 carries load_start; returns the cycle number where load_done (or load_err) appears
   task automatic run_load(input logic [KW-1:0] key, input bit gap, input bit poke, input bit bad_par,
                           input logic [KW-1:0] old_key, input logic old_lock,
                           output int cyc, output bit hold_ok, output bit err_seen);
      int  n;
      logic pb;
      n = 0;
      pb = (^key) ^ bad_par;
      hold_ok = 1'b1;
      err_seen = 1'b0;
      cyc = -1;
      bus.load_start = 1'b1;
      bus.key_valid = poke;
      bus.key_bit = ~key[0];
      tick;
      for (int c = 2; c < 300; c++) begin
         if (bus.key_out !== old_key || bus.key_locked !== old_lock) hold_ok = 1'b0;
         if (bus.load_done === 1'b1) begin
            cyc = c;
            break;
         end
         if (bus.load_err === 1'b1) begin
            cyc = c;
            err_seen = 1'b1;
            break;
         end
         bus.load_start = poke && c == 10;
         bus.key_valid = (n < KW + PAR) && (!gap || c % 2 == 0);
         bus.key_bit = (n < KW) ? key[n] : pb;
         if (bus.key_valid && bus.key_ready === 1'b1) n++;
         tick;
      end
      bus.load_start = 1'b0;
      bus.key_valid = 1'b0;
   endtask

   initial begin
      logic [KW-1:0] prev_key;
      logic          prev_lock;
      int            cyc;
      bit            hold, err;
      vt[0] = '{40'hA5_5A3C_C3F0, 1'b1, 1'b0, 81, 40'hA5_5A3C_C3F0};
      vt[1] = '{40'hA5_5A3C_C3F0, 1'b0, 1'b0, 42, 40'hA5_5A3C_C3F0};
      vt[2] = '{40'h00_FFFF_0001, 1'b0, 1'b0, 42, 40'h00_FFFF_0001};
      vt[3] = '{40'h12_3456_789A, 1'b0, 1'b1, 42, 40'h12_3456_789A};
      vt[4] = '{40'hFF_FFFF_FFFF, 1'b1, 1'b0, 81, 40'hFF_FFFF_FFFF};
      bus.load_start = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_bit = 1'b0;
      repeat (2) tick;
      rst_n = 1'b1;
      tick;
      chk("rst_key_out", 64'(bus.key_out), 64'h0);
      chk("rst_locked", 64'(bus.key_locked), 64'h0);
      chk("rst_ready", 64'(bus.key_ready), 64'h0);
      chk("rst_done", 64'(bus.load_done), 64'h0);
      chk("rst_err", 64'(bus.load_err), 64'h0);
      bus.load_start = 1'b1;
      tick;
      bus.load_start = 1'b0;
      chk("shift_ready", 64'(bus.key_ready), 64'h1);
      bus.key_valid = 1'b1;
      bus.key_bit = 1'b1;
      repeat (17) tick;
      bus.key_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_key_out", 64'(bus.key_out), 64'h0);
      chk("mid_rst_locked", 64'(bus.key_locked), 64'h0);
      chk("mid_rst_ready", 64'(bus.key_ready), 64'h0);
      chk("mid_rst_done", 64'(bus.load_done), 64'h0);
      tick;
      rst_n = 1'b1;
      tick;
      prev_key = '0;
      prev_lock = 1'b0;
      for (int i = 0; i < 5; i++) begin
         run_load(vt[i].key, vt[i].gap, vt[i].poke, 1'b0, prev_key, prev_lock, cyc, hold, err);
         chk($sformatf("v%0d_done_cycle", i), 64'(cyc), 64'(vt[i].exp_cyc + PAR * (vt[i].gap ? 2 : 1)));
         chk($sformatf("v%0d_key_hold", i), 64'(hold), 64'h1);
         chk($sformatf("v%0d_no_err", i), 64'(err), 64'h0);
         tick;
         chk($sformatf("v%0d_done_pulse", i), 64'(bus.load_done), 64'h0);
         chk($sformatf("v%0d_key_out", i), 64'(bus.key_out), 64'(vt[i].exp_key));
         chk($sformatf("v%0d_locked", i), 64'(bus.key_locked), 64'h1);
         chk($sformatf("v%0d_ready_off", i), 64'(bus.key_ready), 64'h0);
         prev_key = vt[i].exp_key;
         prev_lock = 1'b1;
      end
`ifdef KEY_PARITY_EN
      run_load(40'h1, 1'b0, 1'b0, 1'b0, prev_key, prev_lock, cyc, hold, err);
      chk("par_ok_cycle", 64'(cyc), 64'd43);
      chk("par_ok_err", 64'(err), 64'h0);
      tick;
      chk("par_ok_key", 64'(bus.key_out), 64'h1);
      run_load(40'h3, 1'b0, 1'b0, 1'b1, 40'h1, 1'b1, cyc, hold, err);
      chk("par_bad_err", 64'(err), 64'h1);
      chk("par_bad_cycle", 64'(cyc), 64'd43);
      chk("par_bad_hold", 64'(hold), 64'h1);
      repeat (3) tick;
      chk("par_err_sticky", 64'(bus.load_err), 64'h1);
      chk("par_err_key", 64'(bus.key_out), 64'h1);
      chk("par_err_locked", 64'(bus.key_locked), 64'h1);
      bus.load_start = 1'b1;
      tick;
      bus.load_start = 1'b0;
      chk("par_err_clear", 64'(bus.load_err), 64'h0);
      chk("par_restart_ready", 64'(bus.key_ready), 64'h1);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
